// File: rtl/compare_monitor.sv
// Registered post-processor for a 2-bit magnitude comparator: encodes one-hot flags,
// tallies outcomes in saturating counters and tracks a run of equal samples.
module compare_monitor #(
    parameter int CNT_W     = 8,
    parameter int MATCH_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             a_less_b,
    input  logic             a_equal_b,
    input  logic             a_greater_b,
    output logic [1:0]       result,
    output logic             result_valid,
    output logic             change,
    output logic             error,
    output logic             match_stable,
    output logic [CNT_W-1:0] less_count,
    output logic [CNT_W-1:0] equal_count,
    output logic [CNT_W-1:0] greater_count
);

    localparam int RUN_W = $clog2(MATCH_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MATCH_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        STABLE
    } state_t;

    state_t           state_reg, state_next;
    logic [RUN_W-1:0] run_reg, run_next;
    logic [1:0]       result_reg, result_next;
    logic             result_valid_reg, result_valid_next;
    logic             change_reg, change_next;
    logic             error_reg, error_next;
    logic [CNT_W-1:0] cnt_reg [3];

    // Bit 0 = less, 1 = equal, 2 = greater; index matches cnt_reg.
    logic [2:0] flags;
    logic       one_hot;
    logic       accept;
    logic       malformed;
    logic [1:0] enc;

    assign flags     = {a_greater_b, a_equal_b, a_less_b};
    assign one_hot   = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
    assign accept    = in_valid && one_hot && !clear;
    assign malformed = in_valid && !one_hot && !clear;

    always_comb begin
        enc = 2'b00;
        case (flags)
            3'b001:  enc = 2'b01;
            3'b010:  enc = 2'b10;
            3'b100:  enc = 2'b11;
            default: enc = 2'b00;
        endcase
    end

    always_comb begin
        state_next        = state_reg;
        run_next          = run_reg;
        result_next       = result_reg;
        result_valid_next = 1'b0;
        change_next       = 1'b0;
        error_next        = 1'b0;
        if (clear) begin
            state_next  = IDLE;
            run_next    = '0;
            result_next = 2'b00;
        end else if (accept) begin
            result_next       = enc;
            result_valid_next = 1'b1;
            // The first sample out of IDLE has no meaningful predecessor.
            change_next       = (state_reg != IDLE) && (enc != result_reg);
            if (a_equal_b) begin
                run_next = (run_reg == RUN_MAX) ? run_reg : run_reg + RUN_W'(1);
            end else begin
                run_next = '0;
            end
            state_next = (run_next == RUN_MAX) ? STABLE : TRACK;
        end else if (malformed) begin
            error_next = 1'b1;
            run_next   = '0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            run_reg          <= '0;
            result_reg       <= 2'b00;
            result_valid_reg <= 1'b0;
            change_reg       <= 1'b0;
            error_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            run_reg          <= run_next;
            result_reg       <= result_next;
            result_valid_reg <= result_valid_next;
            change_reg       <= change_next;
            error_reg        <= error_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    cnt_reg[gi] <= '0;
                end else if (accept && flags[gi] && (cnt_reg[gi] != CNT_MAX)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign result        = result_reg;
    assign result_valid  = result_valid_reg;
    assign change        = change_reg;
    assign error         = error_reg;
    assign match_stable  = (state_reg == STABLE);
    assign less_count    = cnt_reg[0];
    assign equal_count   = cnt_reg[1];
    assign greater_count = cnt_reg[2];

endmodule

// File: tb/tb_compare_monitor.sv
// Bench for compare_monitor: a behavioural model pushes expected outputs per driven cycle,
// a monitor pops and compares them; feature tasks add targeted inline checks.
module tb_compare_monitor;

    localparam int ML = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       a_less_b = 1'b0;
    logic       a_equal_b = 1'b0;
    logic       a_greater_b = 1'b0;

    logic [1:0] result;
    logic       result_valid, change, error, match_stable;
    logic [7:0] less_count, equal_count, greater_count;

    logic [1:0] s_result;
    logic       s_result_valid, s_change, s_error, s_match_stable;
    logic [1:0] s_less_count, s_equal_count, s_greater_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] res;
        logic       rv;
        logic       ch;
        logic       err;
        logic       st;
        logic [7:0] l;
        logic [7:0] e;
        logic [7:0] g;
        logic [1:0] sl;
        logic [1:0] se;
        logic [1:0] sg;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    int m_res = 0;
    int m_state = 0;
    int m_run = 0;
    int m_l = 0, m_e = 0, m_g = 0;

    always #5 clk = ~clk;

    compare_monitor #(.CNT_W(8), .MATCH_LEN(ML)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .a_less_b(a_less_b), .a_equal_b(a_equal_b), .a_greater_b(a_greater_b),
        .result(result), .result_valid(result_valid), .change(change), .error(error),
        .match_stable(match_stable), .less_count(less_count), .equal_count(equal_count),
        .greater_count(greater_count)
    );

    compare_monitor #(.CNT_W(2), .MATCH_LEN(ML)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .a_less_b(a_less_b), .a_equal_b(a_equal_b), .a_greater_b(a_greater_b),
        .result(s_result), .result_valid(s_result_valid), .change(s_change), .error(s_error),
        .match_stable(s_match_stable), .less_count(s_less_count), .equal_count(s_equal_count),
        .greater_count(s_greater_count)
    );

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Drive one cycle, predict the outputs that follow the next edge.
    task automatic drive(input logic v, input logic l, input logic e, input logic g,
                         input logic clr, input logic rst);
        exp_t x;
        int   enc;
        reset = rst; clear = clr; in_valid = v;
        a_less_b = l; a_equal_b = e; a_greater_b = g;
        x = '0;
        if (rst || clr) begin
            m_res = 0; m_state = 0; m_run = 0; m_l = 0; m_e = 0; m_g = 0;
        end else if (v) begin
            if (int'(l) + int'(e) + int'(g) == 1) begin
                enc  = l ? 1 : (e ? 2 : 3);
                x.ch = (m_state != 0) && (enc != m_res);
                x.rv = 1'b1;
                m_res = enc;
                if (l) m_l++;
                if (e) m_e++;
                if (g) m_g++;
                m_run   = e ? sat(m_run + 1, ML) : 0;
                m_state = (m_run == ML) ? 2 : 1;
            end else begin
                x.err   = 1'b1;
                m_run   = 0;
                m_state = 0;
            end
        end
        x.res = 2'(m_res);
        x.st  = (m_state == 2);
        x.l   = 8'(sat(m_l, 255));
        x.e   = 8'(sat(m_e, 255));
        x.g   = 8'(sat(m_g, 255));
        x.sl  = 2'(sat(m_l, 3));
        x.se  = 2'(sat(m_e, 3));
        x.sg  = 2'(sat(m_g, 3));
        sb.push_back(x);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t want;
        exp_t got;
        #1;
        if (sb.size() != 0) begin
            want = sb.pop_front();
            got  = {result, result_valid, change, error, match_stable,
                    less_count, equal_count, greater_count,
                    s_less_count, s_equal_count, s_greater_count};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL scoreboard t=%0t got=%h expected=%h", $time, got, want);
            end
        end
    end

    task automatic test_reset();
        drive(1, 0, 1, 0, 0, 1);
        drive(1, 0, 1, 0, 0, 1);
        checks++;
        if ({result, result_valid, change, error, match_stable} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b expected=000000",
                     {result, result_valid, change, error, match_stable});
        end
        checks++;
        if ({less_count, equal_count, greater_count} !== 24'h0) begin
            errors++;
            $display("FAIL reset_counts got=%h expected=000000",
                     {less_count, equal_count, greater_count});
        end
        $display("test_reset done");
    endtask

    task automatic test_stable_match();
        logic seen_change = 1'b0;
        drive(1, 0, 1, 0, 0, 0); seen_change |= change;
        drive(1, 0, 1, 0, 0, 0); seen_change |= change;
        drive(0, 0, 1, 0, 0, 0); seen_change |= change;
        drive(1, 0, 1, 0, 0, 0); seen_change |= change;
        checks++;
        if (match_stable !== 1'b0) begin
            errors++;
            $display("FAIL stable_early got=%b expected=0", match_stable);
        end
        drive(1, 0, 1, 0, 0, 0); seen_change |= change;
        checks++;
        if ({match_stable, result_valid} !== 2'b11) begin
            errors++;
            $display("FAIL stable_rise got=%b expected=11", {match_stable, result_valid});
        end
        checks++;
        if (equal_count !== 8'd4) begin
            errors++;
            $display("FAIL stable_equal_count got=%0d expected=4", equal_count);
        end
        checks++;
        if (seen_change !== 1'b0) begin
            errors++;
            $display("FAIL stable_no_change got=%b expected=0", seen_change);
        end
        $display("test_stable_match done");
    endtask

    task automatic test_run_break();
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        checks++;
        if ({change, result, match_stable} !== 4'b1010) begin
            errors++;
            $display("FAIL break_less got=%b expected=1010", {change, result, match_stable});
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 0, 0, 0);
            checks++;
            if (match_stable !== (i == 3)) begin
                errors++;
                $display("FAIL break_rerun_%0d got=%b expected=%b", i, match_stable, (i == 3));
            end
        end
        checks++;
        if ({less_count, equal_count} !== {8'd1, 8'd7}) begin
            errors++;
            $display("FAIL break_counts got=%0d/%0d expected=1/7", less_count, equal_count);
        end
        $display("test_run_break done");
    endtask

    task automatic test_malformed();
        drive(1, 1, 1, 0, 0, 0);
        checks++;
        if ({error, result_valid, result, match_stable} !== 5'b10100) begin
            errors++;
            $display("FAIL malformed got=%b expected=10100",
                     {error, result_valid, result, match_stable});
        end
        drive(1, 0, 0, 1, 0, 0);
        checks++;
        if ({result, change, result_valid} !== 4'b1101) begin
            errors++;
            $display("FAIL after_malformed got=%b expected=1101", {result, change, result_valid});
        end
        $display("test_malformed done");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 1, 0, 0);
        checks++;
        if (s_greater_count !== 2'd3) begin
            errors++;
            $display("FAIL sat_greater got=%0d expected=3", s_greater_count);
        end
        checks++;
        if (greater_count !== 8'd6) begin
            errors++;
            $display("FAIL wide_greater got=%0d expected=6", greater_count);
        end
        $display("test_saturation done");
    endtask

    task automatic test_priority();
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 0, 0);
        checks++;
        if (match_stable !== 1'b1) begin
            errors++;
            $display("FAIL prio_setup got=%b expected=1", match_stable);
        end
        drive(1, 0, 1, 0, 1, 0);
        checks++;
        if ({equal_count, result, match_stable, result_valid} !== 12'h0) begin
            errors++;
            $display("FAIL prio_clear got=%h expected=000",
                     {equal_count, result, match_stable, result_valid});
        end
        $display("test_priority done");
    endtask

    task automatic test_back_to_back();
        logic [2:0] f;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) f = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 1) == 0) f = 3'b010;
            else f = 3'b001 << $urandom_range(0, 2);
            drive($urandom_range(0, 3) != 0, f[0], f[1], f[2],
                  $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        #2;
        test_reset();
        test_stable_match();
        test_run_break();
        test_malformed();
        test_saturation();
        test_priority();
        test_back_to_back();
        drive(0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
